// File: rtl/clk_ctrl_pkg.sv
// Shared encodings for the lab CPU clock-enable controller: FSM states,
// RUN rate codes, counter widths and the mode-transition function.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_HALT = 2'b11
    } state_e;

    localparam logic [1:0] RATE_SLOW  = 2'd0;
    localparam logic [1:0] RATE_MED   = 2'd1;
    localparam logic [1:0] RATE_FAST  = 2'd2;
    localparam logic [1:0] RATE_EVERY = 2'd3;

    localparam int TICK_W      = 16;
    localparam int SYNC_STAGES = 2;

    // halt_req outranks mode changes; HALT can only fall back into STEP.
    function automatic state_e next_state(input state_e cur, input logic run_mode, input logic halt);
        state_e nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: nxt = run_mode ? ST_RUN : ST_STEP;
            ST_RUN: begin
                if (halt)
                    nxt = ST_HALT;
                else if (!run_mode)
                    nxt = ST_STEP;
            end
            ST_STEP: begin
                if (halt)
                    nxt = ST_HALT;
                else if (run_mode)
                    nxt = ST_RUN;
            end
            ST_HALT: begin
                if (!run_mode)
                    nxt = ST_STEP;
            end
            default: nxt = ST_IDLE;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus stability counter for a bouncing push-button;
// produces the accepted level and a one-cycle pulse on its rising change.
module btn_debounce
    import clk_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] CNT_LAST = DW'(DEB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   btn_s;

    assign btn_s = sync_q[SYNC_STAGES-1];

    // The counter tracks consecutive cycles of disagreement; one agreeing
    // cycle throws the partial count away.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], btn_raw};
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        if (btn_s != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = btn_s;
                rise_d  = btn_s;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/clk_step_ctrl.sv
// Clock-enable sequencer for the lab CPU: divided pulses in RUN, one pulse per
// debounced press in STEP, nothing in HALT. Only clk_en leaves; no derived clock.
module clk_step_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int DIV_SLOW   = 50_000_000,
    parameter int DIV_MED    = 5_000_000,
    parameter int DIV_FAST   = 50_000,
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CNT_W      = 26
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              run_sw,
    input  logic              step_btn,
    input  logic [1:0]        rate_sel,
    input  logic              halt_req,
    output logic              clk_en,
    output logic [1:0]        state,
    output logic [TICK_W-1:0] tick_cnt
);

    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(DIV_SLOW - 1);
    localparam logic [CNT_W-1:0] MED_LAST  = CNT_W'(DIV_MED - 1);
    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(DIV_FAST - 1);

    logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
    logic                   run_sw_s;
    state_e                 state_q, state_d;
    logic [1:0]             rate_q, rate_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   clk_en_q, clk_en_d;
    logic [TICK_W-1:0]      tick_q, tick_d;
    logic [CNT_W-1:0]       div_last;
    logic                   rate_chg;
    logic                   btn_level;
    logic                   btn_rise;

    btn_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_deb (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_raw (step_btn),
        .level   (btn_level),
        .rise    (btn_rise)
    );

    assign run_sw_s = run_sync_q[SYNC_STAGES-1];
    assign rate_chg = (rate_sel != rate_q);

    always_comb begin
        case (rate_q)
            RATE_SLOW: div_last = SLOW_LAST;
            RATE_MED:  div_last = MED_LAST;
            RATE_FAST: div_last = FAST_LAST;
            default:   div_last = '0;
        endcase
    end

    // A pulse is only issued when the FSM stays in the mode that produced it,
    // so a halt or mode change in cycle t kills whatever would land in t+1.
    always_comb begin
        run_sync_d = {run_sync_q[SYNC_STAGES-2:0], run_sw};
        rate_d     = rate_sel;
        state_d    = next_state(state_q, run_sw_s, halt_req);
        cnt_d      = '0;
        clk_en_d   = 1'b0;
        if (state_q == ST_RUN && state_d == ST_RUN) begin
            if (rate_chg) begin
                cnt_d = '0;
            end else if (rate_q == RATE_EVERY) begin
                clk_en_d = 1'b1;
            end else if (cnt_q == div_last) begin
                clk_en_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == ST_STEP && state_d == ST_STEP) begin
            clk_en_d = btn_rise & btn_level;
        end
        tick_d = tick_q + TICK_W'(clk_en_d);
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            run_sync_q <= '0;
            state_q    <= ST_IDLE;
            rate_q     <= RATE_SLOW;
            cnt_q      <= '0;
            clk_en_q   <= 1'b0;
            tick_q     <= '0;
        end else begin
            run_sync_q <= run_sync_d;
            state_q    <= state_d;
            rate_q     <= rate_d;
            cnt_q      <= cnt_d;
            clk_en_q   <= clk_en_d;
            tick_q     <= tick_d;
        end
    end

    assign clk_en   = clk_en_q;
    assign state    = state_q;
    assign tick_cnt = tick_q;

endmodule
